hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It watches the IF/ID, ID/EX and EX/MEM stages and drives the stage enables: PC write, IF/ID write/flush, and the `Bubble` input of `PipelinedControl`, which zeroes all control fields entering EX. It handles load-use interlocks, taken-branch and jump squashing, and variable-latency data-memory waits, with a watchdog on those waits.

## Interface
- `MAX_WAIT`, 15: maximum consecutive memory-wait cycles before the watchdog forces release (range 1–255).
- `CNT_W`, 16: width of the performance counters.

Ports:
- `CLK` in 1: rising-edge clock.
- `Reset_L` in 1: asynchronous, active-low reset.
- `IFID_Opcode` in 6: opcode of the instruction in ID.
- `IFID_Rs` in 5: rs field in ID.
- `IFID_Rt` in 5: rt field in ID.
- `IDEX_MemRead` in 1: instruction in EX is a load.
- `IDEX_Rt` in 5: destination of that load.
- `EX_BranchTaken` in 1: BEQ resolved taken in EX this cycle.
- `MEM_Req` in 1: the MEM-stage instruction accesses data memory.
- `DMemReady` in 1: data memory completes the access this cycle.
- `PCWrite` out 1: PC register enable.
- `IFIDWrite` out 1: IF/ID register enable.
- `IFIDFlush` out 1: load NOP into IF/ID.
- `Bubble` out 1: to `PipelinedControl`; zero the ID/EX controls.
- `Stall` out 1: freeze the ID/EX, EX/MEM and MEM/WB registers.
- `Timeout` out 1: sticky watchdog flag.
- `StallCount` out `CNT_W`: performance counter.
- `FlushCount` out `CNT_W`: performance counter.

## Operation
State register: `RUN` and `WAIT`, plus an 8-bit wait counter `wcnt`. Outputs are Mealy: state plus current inputs, combinational, valid before the capturing edge.

Operand use is decoded from `IFID_Opcode`:
- rs is used by everything except J (000010) and LUI (001111).
- rt is used by R-type (000000), BEQ (000100) and SW (101011).
- Register 0 never causes a hazard.

Conditions:
- `loaduse` = `IDEX_MemRead` & `IDEX_Rt`≠0 & ((uses rs & `IFID_Rs`==`IDEX_Rt`) | (uses rt & `IFID_Rt`==`IDEX_Rt`)).
- `memwait` = (state==`RUN` & `MEM_Req` & !`DMemReady`) | (state==`WAIT` & !`DMemReady` & `wcnt`<`MAX_WAIT`).

Output priority, highest first:
1. `memwait`: `Stall`=1, `PCWrite`=0, `IFIDWrite`=0, `Bubble`=0, `IFIDFlush`=0. The whole pipeline is frozen and hazards are re-evaluated once it releases.
2. `EX_BranchTaken`: `PCWrite`=1, `IFIDFlush`=1, `Bubble`=1. Squashes both IF and ID, and overrides any load-use on the squashed ID instruction.
3. `loaduse`: `PCWrite`=0, `IFIDWrite`=0, `Bubble`=1, `IFIDFlush`=0.
4. J in ID: `PCWrite`=1, `IFIDFlush`=1, `Bubble`=0. The jump proceeds and the fetched slot is squashed.
5. Otherwise: `PCWrite`=1, `IFIDWrite`=1, all other outputs 0.

FSM:
- `RUN`→`WAIT` when `MEM_Req` & !`DMemReady`; `wcnt`←1.
- `WAIT`, while !`DMemReady` & `wcnt`<`MAX_WAIT`: stay in `WAIT`, `wcnt`++.
- `WAIT`→`RUN` when `DMemReady`. That cycle is unstalled and the access completes.
- `WAIT`→`RUN` when `wcnt`==`MAX_WAIT`. That cycle is unstalled (forced release), `Timeout`←1, and `Timeout` stays set until reset.
- `wcnt` clears on every return to `RUN`.

## Timing
- Reset (`Reset_L`=0, asynchronous) sets state `RUN`, `wcnt`=0, `Timeout`=0 and both counters to 0.
- While reset is held, outputs are forced to `PCWrite`=0, `IFIDWrite`=0, `IFIDFlush`=1, `Bubble`=1, `Stall`=0. Asserting reset mid-`WAIT` drops straight to `RUN`.
- Load-use costs exactly 1 cycle. The bubble drives `IDEX_MemRead` to 0 on the next cycle, which clears the condition.
- Branch costs 2 squashed slots in a single cycle. Jump costs 1.
- A memory access with latency L stalls for min(L−1, `MAX_WAIT`) cycles.
- `DMemReady` coincident with `MEM_Req` in `RUN` means no stall.

## Configuration
`HAZARD_PERF_CNT_EN`:
- Defined: on each clock edge out of reset, `StallCount` increments if `Stall` | `loaduse`-stall, and `FlushCount` increments if `IFIDFlush`. Both saturate at all-ones.
- Not defined: both counters are omitted and the ports are tied to 0.

## Test plan
- LW $5 in EX, ADD $6,$5,$1 in ID → one cycle with `Bubble`=1, `PCWrite`=0, `IFIDWrite`=0; the next cycle is normal.
- LW $0 in EX, and separately LW $5 in EX with LUI $5 in ID → no stall in either case.
- `EX_BranchTaken`=1 at the same time as a load-use hazard → `PCWrite`=1, `IFIDFlush`=1, `Bubble`=1; `FlushCount` +1.
- `MEM_Req`=1 with `DMemReady` rising 3 cycles later → `Stall`=1 for exactly 3 cycles, state back to `RUN`, `Timeout`=0.
- `MAX_WAIT`=4 with `DMemReady` held at 0 → `Stall` for 4 cycles, forced release, `Timeout`=1 and sticky until `Reset_L` pulses low.
- Reset asserted during `WAIT` → outputs take their reset values immediately; after release the controller is in `RUN` with the counters at 0.

Source files
------------

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - MIPS pipeline hazard/stall sequencer with memory-wait watchdog
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined; otherwise tied to 0.
module hazard_controller #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic [5:0]       IFID_Opcode,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Req,
  input  logic             DMemReady,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             Bubble,
  output logic             Stall,
  output logic             Timeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [7:0] MAX_W    = 8'(MAX_WAIT);

  typedef enum logic {RUN, WAIT} state_t;

  state_t     state;
  logic [7:0] wcnt;

  logic usesRs;
  logic usesRt;
  logic isJump;
  logic loadUse;
  logic memWait;

  assign usesRs  = (IFID_Opcode != OP_J) && (IFID_Opcode != OP_LUI);
  assign usesRt  = (IFID_Opcode == OP_RTYPE) || (IFID_Opcode == OP_BEQ) || (IFID_Opcode == OP_SW);
  assign isJump  = (IFID_Opcode == OP_J);

  // $0 is hard-wired, so a load targeting it never creates a dependency
  assign loadUse = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                   ((usesRs && (IFID_Rs == IDEX_Rt)) || (usesRt && (IFID_Rt == IDEX_Rt)));

  assign memWait = ((state == RUN)  && MEM_Req && !DMemReady) ||
                   ((state == WAIT) && !DMemReady && (wcnt < MAX_W));

  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    Bubble    = 1'b0;
    Stall     = 1'b0;
    if (!Reset_L) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      Bubble    = 1'b1;
    end else if (memWait) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      Stall     = 1'b1;
    end else if (EX_BranchTaken) begin
      IFIDFlush = 1'b1;
      Bubble    = 1'b1;
    end else if (loadUse) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      Bubble    = 1'b1;
    end else if (isJump) begin
      IFIDFlush = 1'b1;
    end
  end

  // Release from WAIT is unstalled either way; only a non-ready release trips the watchdog
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state   <= RUN;
      wcnt    <= 8'd0;
      Timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (MEM_Req && !DMemReady) begin
            state <= WAIT;
            wcnt  <= 8'd1;
          end
        end
        WAIT: begin
          if (DMemReady) begin
            state <= RUN;
            wcnt  <= 8'd0;
          end else if (wcnt < MAX_W) begin
            wcnt <= wcnt + 8'd1;
          end else begin
            state   <= RUN;
            wcnt    <= 8'd0;
            Timeout <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
          wcnt  <= 8'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stallEvent;

  // A load-use stall counts only when it actually wins priority
  assign stallEvent = Stall || (loadUse && !memWait && !EX_BranchTaken);

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stallEvent && (StallCount != {CNT_W{1'b1}}))
        StallCount <= StallCount + CNT_W'(1);
      if (IFIDFlush && (FlushCount != {CNT_W{1'b1}}))
        FlushCount <= FlushCount + CNT_W'(1);
    end
  end
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - scoreboard bench for hazard_controller with a rule-level reference model
module tb_hazard_controller;

  localparam int MAXW  = 4;
  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             Reset_L = 1'b0;
  logic [5:0]       IFID_Opcode = '0;
  logic [4:0]       IFID_Rs = '0;
  logic [4:0]       IFID_Rt = '0;
  logic             IDEX_MemRead = 1'b0;
  logic [4:0]       IDEX_Rt = '0;
  logic             EX_BranchTaken = 1'b0;
  logic             MEM_Req = 1'b0;
  logic             DMemReady = 1'b0;
  logic             PCWrite, IFIDWrite, IFIDFlush, Bubble, Stall, Timeout;
  logic [CNT_W-1:0] StallCount, FlushCount;

  hazard_controller #(.MAX_WAIT(MAXW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .IFID_Opcode(IFID_Opcode), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .EX_BranchTaken(EX_BranchTaken), .MEM_Req(MEM_Req), .DMemReady(DMemReady),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .Bubble(Bubble), .Stall(Stall), .Timeout(Timeout),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          idx;
    logic [5:0]  outs;   // {PCWrite, IFIDWrite, IFIDFlush, Bubble, Stall, Timeout}
    logic [5:0]  mask;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  // Reference model state: are we inside a memory access wait, and for how long
  bit mInWait  = 1'b0;
  int mWaited  = 0;
  bit mTimeout = 1'b0;
  int mSc      = 0;
  int mFc      = 0;

  task automatic step();
    exp_t e;
    bit useRs, useRt, lu, mw, flush;
    e.idx  = cycle;
    e.mask = 6'b111111;
    if (!Reset_L) begin
      mInWait = 0; mWaited = 0; mTimeout = 0; mSc = 0; mFc = 0;
      e.outs = 6'b001100;
      e.sc = '0; e.fc = '0;
    end else begin
      useRs = !(IFID_Opcode inside {6'b000010, 6'b001111});
      useRt = IFID_Opcode inside {6'b000000, 6'b000100, 6'b101011};
      lu = IDEX_MemRead && (IDEX_Rt != 0) &&
           ((useRs && IFID_Rs == IDEX_Rt) || (useRt && IFID_Rt == IDEX_Rt));
      mw = mInWait ? (!DMemReady && mWaited < MAXW) : (MEM_Req && !DMemReady);
      e.sc = 16'(mSc);
      e.fc = 16'(mFc);
      if (mw)                          e.outs = {5'b00001, mTimeout};
      else if (EX_BranchTaken) begin   e.outs = {5'b10110, mTimeout}; e.mask = 6'b101111; end
      else if (lu)                     e.outs = {5'b00010, mTimeout};
      else if (IFID_Opcode == 6'b000010) begin e.outs = {5'b10100, mTimeout}; e.mask = 6'b101111; end
      else                             e.outs = {5'b11000, mTimeout};
      flush = e.outs[3];
`ifdef HAZARD_PERF_CNT_EN
      if ((mw || (lu && !EX_BranchTaken)) && mSc < 65535) mSc++;
      if (flush && mFc < 65535) mFc++;
`endif
      if (mw) begin
        mInWait = 1; mWaited++;
      end else if (mInWait) begin
        if (!DMemReady) mTimeout = 1;
        mInWait = 0; mWaited = 0;
      end
    end
    q.push_back(e);
  endtask

  task automatic cyc(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                     input logic mr, input logic [4:0] xrt, input logic br,
                     input logic req, input logic rdy, input logic rst = 1'b1);
    Reset_L = rst; IFID_Opcode = op; IFID_Rs = rs; IFID_Rt = rt;
    IDEX_MemRead = mr; IDEX_Rt = xrt; EX_BranchTaken = br; MEM_Req = req; DMemReady = rdy;
    step();
    @(posedge CLK); #1;
    cycle++;
  endtask

  initial begin : monitor
    logic [5:0] act;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        me  = q.pop_front();
        act = {PCWrite, IFIDWrite, IFIDFlush, Bubble, Stall, Timeout};
        checks++;
        if ((act & me.mask) !== (me.outs & me.mask)) begin
          errors++;
          $display("FAIL outs cyc=%0d actual=%b expected=%b mask=%b", me.idx, act, me.outs, me.mask);
        end
        checks++;
        if (StallCount !== me.sc || FlushCount !== me.fc) begin
          errors++;
          $display("FAIL counters cyc=%0d actual=%0d/%0d expected=%0d/%0d",
                   me.idx, StallCount, FlushCount, me.sc, me.fc);
        end
      end
    end
  end

  initial begin : stimulus
    logic [5:0] ops [7];
    ops = '{6'b000000, 6'b000100, 6'b101011, 6'b100011, 6'b000010, 6'b001111, 6'b001000};
    @(posedge CLK); #1;
    cyc(6'h00, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    cyc(6'h00, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    // load-use then recovery
    cyc(6'b000000, 5, 1, 1, 5, 0, 0, 0);
    cyc(6'b000000, 5, 1, 0, 0, 0, 0, 0);
    // no hazard: load to $0, and LUI not reading rt
    cyc(6'b000000, 0, 0, 1, 0, 0, 0, 0);
    cyc(6'b001111, 0, 5, 1, 5, 0, 0, 0);
    cyc(6'b101011, 2, 5, 1, 5, 0, 0, 0);
    // branch over load-use, then jump
    cyc(6'b000000, 5, 1, 1, 5, 1, 0, 0);
    cyc(6'b000010, 5, 5, 1, 5, 0, 0, 0);
    // memory access ready after 3 waits
    repeat (3) cyc(6'b000000, 1, 2, 0, 0, 0, 1, 0);
    cyc(6'b000000, 1, 2, 0, 0, 0, 1, 1);
    cyc(6'b000000, 1, 2, 0, 0, 0, 0, 0);
    // coincident ready: no stall
    cyc(6'b000000, 1, 2, 0, 0, 0, 1, 1);
    // watchdog expiry, sticky, then cleared by reset
    repeat (5) cyc(6'b000000, 1, 2, 0, 0, 0, 1, 0);
    repeat (3) cyc(6'b000000, 1, 2, 0, 0, 0, 0, 0);
    cyc(6'b000000, 1, 2, 0, 0, 0, 0, 0, 1'b0);
    cyc(6'b000000, 1, 2, 0, 0, 0, 0, 0);
    // reset mid-wait
    repeat (2) cyc(6'b000000, 1, 2, 0, 0, 0, 1, 0);
    cyc(6'b000000, 1, 2, 0, 0, 0, 1, 0, 1'b0);
    cyc(6'b000000, 1, 2, 0, 0, 0, 0, 0);
    cyc(6'b000000, 3, 3, 1, 3, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      cyc(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 99) != 0));
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
